// File: rtl/fft_frame_sched.sv
// Frame scheduler for the 256-point FFT core: queues requests, issues START,
// frames the phase-aligned 64-beat load window and the DONE-framed drain.
module fft_frame_sched #(
    parameter int FRAME_BEATS = 64,
    parameter int COOL_CYCLES = 3,
    parameter int TIMEOUT     = 1024,
    parameter int REQ_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    output logic        REQ_FULL,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic        ZERO_FILL,
    output logic        START,
    input  logic        DONE,
    output logic        OUT_VALID,
    output logic        OUT_LAST,
    input  logic        OUT_READY,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT,
    output logic        ERR_UNDERRUN,
    output logic        ERR_OVERRUN,
    output logic        ERR_TIMEOUT,
    input  logic        CLR_ERR
);

    localparam int PW   = $clog2(REQ_DEPTH + 1);
    localparam int BW   = $clog2(FRAME_BEATS) + 1;
    localparam int CMAX = (TIMEOUT > COOL_CYCLES) ? TIMEOUT : COOL_CYCLES;
    localparam int WW   = $clog2(CMAX + 1);

    localparam logic [PW-1:0] PEND_FULL = PW'(REQ_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] COOL_LAST = WW'(COOL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LOAD,
        S_WAIT,
        S_DRAIN,
        S_COOL
    } state_t;

    state_t        state_q;
    logic [PW-1:0] pend_q, pend_d;
    logic [BW-1:0] beat_q;
    logic [WW-1:0] wait_q;
    logic [15:0]   frame_q;
    logic [2:0]    err_q, err_d;

    logic full, dec, acc, set_u, set_o, set_t;

    assign full      = (pend_q == PEND_FULL);
    assign IN_READY  = (state_q == S_LOAD);
    assign ZERO_FILL = IN_READY & ~IN_VALID;
    assign START     = (state_q == S_ARM);
    assign OUT_VALID = (state_q == S_DRAIN) & DONE;
    assign OUT_LAST  = (state_q == S_DRAIN) && (beat_q == LAST_BEAT);
    assign BUSY      = (state_q != S_IDLE);
    assign REQ_FULL  = full;
    assign FRAME_CNT = frame_q;

    assign ERR_UNDERRUN = err_q[0];
    assign ERR_OVERRUN  = err_q[1];
    assign ERR_TIMEOUT  = err_q[2];

    always_comb begin
        dec    = (state_q == S_IDLE) && (pend_q != '0);
        // a request landing on the dequeue edge always fits
        acc    = REQ && (!full || dec);
        pend_d = pend_q;
        if (acc && !dec) begin
            pend_d = pend_q + PW'(1);
        end else if (!acc && dec) begin
            pend_d = pend_q - PW'(1);
        end
        set_u = (state_q == S_LOAD) && !IN_VALID;
        set_o = OUT_VALID && !OUT_READY;
        set_t = (state_q == S_WAIT) && !DONE && (wait_q == WAIT_LAST);
        err_d = (err_q & ~{3{CLR_ERR}}) | {set_t, set_o, set_u};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            frame_q <= '0;
            err_q   <= '0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
            unique case (state_q)
                S_IDLE: begin
                    if (dec) state_q <= S_ARM;
                end
                S_ARM: begin
                    state_q <= S_LOAD;
                    beat_q  <= '0;
                end
                S_LOAD: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q <= S_WAIT;
                        wait_q  <= '0;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                S_WAIT: begin
                    if (DONE) begin
                        state_q <= S_DRAIN;
                        beat_q  <= '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_COOL;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                S_DRAIN: begin
                    if (DONE) begin
                        beat_q <= beat_q + BW'(1);
                    end else begin
                        state_q <= S_COOL;
                        wait_q  <= '0;
                        frame_q <= frame_q + 16'd1;
                    end
                end
                S_COOL: begin
                    if (wait_q == COOL_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: timestamp-based reference model, a simple
// core model driving DONE, directed scenarios followed by random traffic.
module tb_fft_frame_sched;

    localparam int FB = 64;
    localparam int CC = 3;
    localparam int TO = 1024;
    localparam int RD = 4;

    logic        CLK = 1'b0;
    logic        RST, REQ, REQ_FULL, IN_VALID, IN_READY, ZERO_FILL, START;
    logic        DONE, OUT_VALID, OUT_LAST, OUT_READY, BUSY, CLR_ERR;
    logic [15:0] FRAME_CNT;
    logic        ERR_UNDERRUN, ERR_OVERRUN, ERR_TIMEOUT;

    always #5 CLK = ~CLK;

    fft_frame_sched #(
        .FRAME_BEATS(FB), .COOL_CYCLES(CC), .TIMEOUT(TO), .REQ_DEPTH(RD)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_FULL(REQ_FULL),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ZERO_FILL(ZERO_FILL),
        .START(START), .DONE(DONE), .OUT_VALID(OUT_VALID),
        .OUT_LAST(OUT_LAST), .OUT_READY(OUT_READY), .BUSY(BUSY),
        .FRAME_CNT(FRAME_CNT), .ERR_UNDERRUN(ERR_UNDERRUN),
        .ERR_OVERRUN(ERR_OVERRUN), .ERR_TIMEOUT(ERR_TIMEOUT),
        .CLR_ERR(CLR_ERR)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // reference model: phase plus entry timestamp
    typedef enum int {P_IDLE, P_ARM, P_LOAD, P_WAIT, P_DRAIN, P_COOL} ph_t;
    ph_t ph = P_IDLE;
    int  t0 = 0, cyc = 0, pend = 0, frames = 0, dbeats = 0;
    bit  eu = 0, eo = 0, et = 0, mvalid = 0;

    // core model: DONE leads its first output beat by one cycle
    int  don = 0, doff = 0, lat = 3;
    bit  core_en = 1;

    int  vmode = 0, rmode = 0;
    bit  clr_on_ovr = 0;

    int  n_start, first_start, n_ready, first_ready, last_ready;
    int  n_valid, n_last, last_at, n_zf, zf_first, zf_last, n_busy;
    int  t_fall, gap_n, gap_bad, exp_frames;
    bit  full_seen, prev_done;

    task automatic clear_obs();
        n_start = 0; first_start = -1; n_ready = 0; first_ready = -1;
        last_ready = -1; n_valid = 0; n_last = 0; last_at = -1;
        n_zf = 0; zf_first = -1; zf_last = -1; n_busy = 0;
        t_fall = -1; gap_n = 0; gap_bad = 0; full_seen = 0;
    endtask

    task automatic go(ph_t p);
        ph = p;
        t0 = cyc + 1;
    endtask

    task automatic model_step(int age);
        bit dec, acc;
        if (RST) begin
            ph = P_IDLE; t0 = cyc + 1; pend = 0; frames = 0;
            eu = 0; eo = 0; et = 0; dbeats = 0; don = 0; doff = 0;
            mvalid = 1;
            return;
        end
        dec  = (ph == P_IDLE) && (pend != 0);
        acc  = REQ && ((pend < RD) || dec);
        pend = pend + int'(acc) - int'(dec);
        eu = (eu && !CLR_ERR) || (ph == P_LOAD && !IN_VALID);
        eo = (eo && !CLR_ERR) || (ph == P_DRAIN && DONE && !OUT_READY);
        et = (et && !CLR_ERR) || (ph == P_WAIT && !DONE && age == TO - 1);
        case (ph)
            P_IDLE:  if (dec) go(P_ARM);
            P_ARM: begin
                go(P_LOAD);
                don  = cyc + 1 + FB + lat;
                doff = don + FB + 1;
            end
            P_LOAD:  if (age == FB - 1) go(P_LOAD == P_LOAD ? P_WAIT : P_WAIT);
            P_WAIT: begin
                if (DONE) begin
                    go(P_DRAIN);
                    dbeats = 0;
                end else if (age == TO - 1) begin
                    go(P_COOL);
                end
            end
            P_DRAIN: begin
                if (DONE) dbeats++;
                else begin
                    go(P_COOL);
                    frames++;
                end
            end
            P_COOL:  if (age == CC - 1) go(P_IDLE);
            default: go(P_IDLE);
        endcase
    endtask

    task automatic tick();
        int age = cyc - t0;
        DONE = core_en && (cyc >= don) && (cyc < doff);
        case (vmode)
            1:       IN_VALID = ($urandom_range(0, 9) != 0);
            2:       IN_VALID = !(ph == P_LOAD && (age == 10 || age == 11));
            default: IN_VALID = 1'b1;
        endcase
        case (rmode)
            1:       OUT_READY = ($urandom_range(0, 9) != 0);
            2:       OUT_READY = !(ph == P_DRAIN && DONE && dbeats == 5);
            default: OUT_READY = 1'b1;
        endcase
        if (clr_on_ovr) CLR_ERR = (ph == P_DRAIN && DONE && dbeats == 5);
        @(negedge CLK);
        if (mvalid) begin
            chk("START", START, ph == P_ARM);
            chk("IN_READY", IN_READY, ph == P_LOAD);
            chk("ZERO_FILL", ZERO_FILL, ph == P_LOAD && !IN_VALID);
            chk("OUT_VALID", OUT_VALID, ph == P_DRAIN && DONE);
            chk("OUT_LAST", OUT_LAST, ph == P_DRAIN && dbeats == FB - 1);
            chk("BUSY", BUSY, ph != P_IDLE);
            chk("REQ_FULL", REQ_FULL, pend == RD);
            chk("FRAME_CNT", FRAME_CNT, frames & 16'hffff);
            chk("ERR_UNDERRUN", ERR_UNDERRUN, eu);
            chk("ERR_OVERRUN", ERR_OVERRUN, eo);
            chk("ERR_TIMEOUT", ERR_TIMEOUT, et);
        end
        if (START === 1'b1) begin
            if (n_start == 0) first_start = cyc;
            n_start++;
            if (t_fall >= 0) begin
                gap_n++;
                if (cyc != t_fall + 5) gap_bad++;
                t_fall = -1;
            end
        end
        if (IN_READY === 1'b1) begin
            if (n_ready == 0) first_ready = cyc;
            last_ready = cyc;
            n_ready++;
        end
        if (ZERO_FILL === 1'b1) begin
            if (n_zf == 0) zf_first = cyc - first_ready;
            zf_last = cyc - first_ready;
            n_zf++;
        end
        if (OUT_VALID === 1'b1) begin
            if (OUT_LAST === 1'b1) last_at = n_valid;
            n_valid++;
        end
        if (OUT_LAST === 1'b1) n_last++;
        if (REQ_FULL === 1'b1) full_seen = 1;
        if (BUSY === 1'b1) n_busy++;
        if (prev_done && !DONE) t_fall = cyc;
        prev_done = DONE;
        @(posedge CLK);
        model_step(age);
        cyc++;
        #1;
    endtask

    task automatic run_idle(int budget, string tag);
        int n = 0;
        while (!(ph == P_IDLE && pend == 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, n < budget, 1);
    endtask

    task automatic pulse_req();
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
    endtask

    initial begin
        int req_cyc, n;
        RST = 1'b1; REQ = 1'b0; CLR_ERR = 1'b0; DONE = 1'b0;
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        prev_done = 0;
        clear_obs();
        repeat (2) tick();
        RST = 1'b0;
        tick();
        exp_frames = 0;

        // single frame
        clear_obs();
        req_cyc = cyc;
        pulse_req();
        run_idle(400, "sf_budget");
        exp_frames += 1;
        chk("sf_start_cyc", first_start, req_cyc + 2);
        chk("sf_n_start", n_start, 1);
        chk("sf_first_ready", first_ready, req_cyc + 3);
        chk("sf_last_ready", last_ready, req_cyc + 66);
        chk("sf_n_ready", n_ready, FB);
        chk("sf_n_valid", n_valid, FB);
        chk("sf_n_last", n_last, 1);
        chk("sf_last_at", last_at, FB - 1);
        chk("sf_frames", FRAME_CNT, exp_frames);
        chk("sf_errs", {ERR_UNDERRUN, ERR_OVERRUN, ERR_TIMEOUT}, 0);

        // back-to-back
        clear_obs();
        REQ = 1'b1;
        repeat (3) tick();
        REQ = 1'b0;
        run_idle(1000, "b2b_budget");
        exp_frames += 3;
        chk("b2b_n_start", n_start, 3);
        chk("b2b_gap_n", gap_n, 2);
        chk("b2b_gap_bad", gap_bad, 0);
        chk("b2b_full_seen", full_seen, 0);
        chk("b2b_frames", FRAME_CNT, exp_frames);

        // request saturation
        clear_obs();
        pulse_req();
        repeat (3) tick();
        REQ = 1'b1;
        repeat (6) tick();
        REQ = 1'b0;
        chk("sat_full", REQ_FULL, 1);
        run_idle(2000, "sat_budget");
        exp_frames += 5;
        chk("sat_n_start", n_start, 5);
        chk("sat_frames", FRAME_CNT, exp_frames);

        // underrun on LOAD beats 10 and 11
        clear_obs();
        vmode = 2;
        pulse_req();
        run_idle(400, "ur_budget");
        vmode = 0;
        exp_frames += 1;
        chk("ur_n_zf", n_zf, 2);
        chk("ur_zf_first", zf_first, 10);
        chk("ur_zf_last", zf_last, 11);
        chk("ur_flag", ERR_UNDERRUN, 1);
        chk("ur_frames", FRAME_CNT, exp_frames);
        repeat (5) tick();
        chk("ur_held", ERR_UNDERRUN, 1);
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        chk("ur_cleared", ERR_UNDERRUN, 0);

        // overrun on output beat 5, clear, then clear against a new violation
        clear_obs();
        rmode = 2;
        pulse_req();
        run_idle(400, "ov_budget");
        exp_frames += 1;
        chk("ov_flag", ERR_OVERRUN, 1);
        chk("ov_n_valid", n_valid, FB);
        chk("ov_last_at", last_at, FB - 1);
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
        chk("ov_cleared", ERR_OVERRUN, 0);
        clr_on_ovr = 1;
        pulse_req();
        run_idle(400, "ov2_budget");
        clr_on_ovr = 0;
        CLR_ERR = 1'b0;
        rmode = 0;
        exp_frames += 1;
        chk("ov_set_wins", ERR_OVERRUN, 1);
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;

        // timeout: core never raises DONE
        clear_obs();
        core_en = 0;
        pulse_req();
        run_idle(1300, "to_budget");
        core_en = 1;
        chk("to_flag", ERR_TIMEOUT, 1);
        chk("to_frames", FRAME_CNT, exp_frames);
        chk("to_busy_cycles", n_busy, 1 + FB + TO + CC);
        chk("to_n_valid", n_valid, 0);

        // reset in the middle of LOAD
        pulse_req();
        n = 0;
        while (!(ph == P_LOAD && cyc - t0 == 20) && n < 200) begin
            tick();
            n++;
        end
        chk("rst_reach_load", n < 200, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_frames = 0;
        chk("rst_outs",
            {START, IN_READY, ZERO_FILL, OUT_VALID, OUT_LAST, BUSY,
             REQ_FULL, ERR_UNDERRUN, ERR_OVERRUN, ERR_TIMEOUT}, 0);
        chk("rst_frames", FRAME_CNT, exp_frames);
        tick();

        // random traffic against the model
        vmode = 1;
        rmode = 1;
        for (int i = 0; i < 3000; i++) begin
            REQ     = ($urandom_range(0, 29) == 0);
            CLR_ERR = ($urandom_range(0, 63) == 0);
            lat     = $urandom_range(0, 8);
            tick();
        end
        REQ = 1'b0;
        CLR_ERR = 1'b0;
        run_idle(6000, "rnd_budget");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
